// File: rtl/agex_muldiv_seq.sv
// agex_muldiv_seq: iterative M-extension multiply/divide unit beside AGEX.
// Computes one bit per cycle: shift-add multiply and restoring divide.
// While an op is in flight it holds FE/DE/AGEX through stall_out, then
// hands result/rd_out back to AGEX with a one-cycle done pulse.
// Optional macro MULDIV_FASTPATH_EN: trivial ops (multiply by zero,
// divide by zero) skip the iteration phase and complete one cycle after start.
module agex_muldiv_seq #(
    parameter int DBITS   = 32,
    parameter int CNTBITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [DBITS-1:0] a,
    input  logic [DBITS-1:0] b,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             stall_out,
    output logic             busy,
    output logic             done,
    output logic [DBITS-1:0] result,
    output logic [4:0]       rd_out
);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_REM   = 3'd4;
    localparam logic [2:0] OP_REMU  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNTBITS-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic [4:0]           r_rd;
    logic [DBITS-1:0]     r_opnd;     // multiplicand, or divisor magnitude
    logic [2*DBITS-1:0]   r_prod;     // {hi, lo}: product, or {remainder, quotient}
    logic                 r_qneg;     // negate quotient in DONE
    logic                 r_rneg;     // negate remainder in DONE
    logic [DBITS-1:0]     r_result;   // last committed result
    logic [4:0]           r_rd_out;   // rd of last committed result

    // Decode of the op offered by AGEX this cycle
    logic             w_valid;
    logic             w_accept;
    logic             w_is_mul_in;
    logic             w_signed_in;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [DBITS-1:0] w_a_mag;
    logic [DBITS-1:0] w_b_mag;
    logic             w_fast;

    assign w_valid     = (op <= OP_REMU);
    assign w_accept    = (r_state == ST_IDLE) & start & w_valid & ~flush;
    assign w_is_mul_in = (op == OP_MUL) | (op == OP_MULHU);
    assign w_signed_in = (op == OP_DIV) | (op == OP_REM);
    assign w_a_neg     = w_signed_in & a[DBITS-1];
    assign w_b_neg     = w_signed_in & b[DBITS-1];
    assign w_a_mag     = w_a_neg ? -a : a;
    assign w_b_mag     = w_b_neg ? -b : b;

`ifdef MULDIV_FASTPATH_EN
    assign w_fast = w_is_mul_in ? ((a == '0) | (b == '0)) : (b == '0);
`else
    assign w_fast = 1'b0;
`endif

    // One iteration of either algorithm, selected by the captured op
    logic             w_is_mul;
    logic             w_last;
    logic [DBITS:0]   w_mul_sum;
    logic [DBITS:0]   w_rem_sh;
    logic [DBITS:0]   w_diff;
    logic             w_qbit;
    logic [DBITS-1:0] w_rem_new;
    logic [2*DBITS-1:0] w_step;

    assign w_is_mul  = (r_op == OP_MUL) | (r_op == OP_MULHU);
    assign w_last    = (r_cnt == CNTBITS'(DBITS - 1));
    // Shift-add: low half holds the unconsumed multiplier bits
    assign w_mul_sum = {1'b0, r_prod[2*DBITS-1:DBITS]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    // Restoring divide: bring in the next dividend bit and try a subtract;
    // a borrow into the top bit means the divisor did not fit
    assign w_rem_sh  = r_prod[2*DBITS-1:DBITS-1];
    assign w_diff    = w_rem_sh - {1'b0, r_opnd};
    assign w_qbit    = ~w_diff[DBITS];
    assign w_rem_new = w_qbit ? w_diff[DBITS-1:0] : w_rem_sh[DBITS-1:0];
    assign w_step    = w_is_mul ? {w_mul_sum, r_prod[DBITS-1:1]}
                                : {w_rem_new, r_prod[DBITS-2:0], w_qbit};

    // Final result selection and sign correction, valid in DONE
    logic [DBITS-1:0] w_quot;
    logic [DBITS-1:0] w_rem;
    logic [DBITS-1:0] w_final;

    assign w_quot = r_qneg ? -r_prod[DBITS-1:0] : r_prod[DBITS-1:0];
    assign w_rem  = r_rneg ? -r_prod[2*DBITS-1:DBITS] : r_prod[2*DBITS-1:DBITS];

    // Pick the architectural result for the captured op
    always_comb begin
        // NOTE: default assignment first so every path drives w_final and no latch is inferred.
        w_final = '0;
        case (r_op)
            OP_MUL:            w_final = r_prod[DBITS-1:0];
            OP_MULHU:          w_final = r_prod[2*DBITS-1:DBITS];
            OP_DIV, OP_DIVU:   w_final = w_quot;
            OP_REM, OP_REMU:   w_final = w_rem;
            default:           w_final = '0;
        endcase
    end

    // Sequencer FSM: capture in IDLE, iterate in CALC, commit in DONE
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_opnd   <= '0;
            r_prod   <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= op;
                        r_rd   <= rd_in;
                        r_cnt  <= '0;
                        r_opnd <= w_is_mul_in ? a : w_b_mag;
                        // Divide by zero keeps quotient all ones: no sign flip
                        r_qneg <= (w_a_neg ^ w_b_neg) & (b != '0);
                        r_rneg <= w_a_neg;
                        if (w_fast) begin
                            // Preload the trivial answer so DONE needs no special case
                            r_prod  <= w_is_mul_in ? '0 : {w_a_mag, {DBITS{1'b1}}};
                            r_state <= ST_DONE;
                        end else begin
                            r_prod  <= w_is_mul_in ? {{DBITS{1'b0}}, b}
                                                   : {{DBITS{1'b0}}, w_a_mag};
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_prod <= w_step;
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A redirect in DONE drops the result; outputs keep old values
                    if (!flush) begin
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                    end
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign stall_out = w_accept | (r_state == ST_CALC);
    assign done      = (r_state == ST_DONE) & ~flush;
    // During the done cycle AGEX sees the fresh value; afterwards the held copy
    assign result    = done ? w_final : r_result;
    assign rd_out    = done ? r_rd    : r_rd_out;

endmodule

// File: doc/agex_muldiv_seq.md
Name: agex_muldiv_seq

Overview:
- Iterative multiply/divide sequencer attached to the AGEX stage.
- Accepts one M-extension op from AGEX and computes it one bit per cycle.
- Holds the front of the pipeline (FE/DE/AGEX latches) via stall_out while computing.
- Returns the result to AGEX for the AGEX latch. Killed by a branch/jump redirect from AGEX.

Parameters:
- DBITS, 32, operand/result width.
- CNTBITS, 6, iteration counter width; must satisfy 2^CNTBITS > DBITS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  AGEX holds a valid mul/div op this cycle.
- op  in  3  0=MUL(low), 1=MULHU(high, unsigned), 2=DIV, 3=DIVU, 4=REM, 5=REMU; codes 6,7 are invalid.
- a  in  DBITS  rs1 value (regval1).
- b  in  DBITS  rs2 value (regval2).
- rd_in  in  5  destination register of the op.
- flush  in  1  redirect from AGEX (br_cond taken); kills the op in flight.
- stall_out  out  1  freeze FE/DE/AGEX latches.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; result and rd_out valid.
- result  out  DBITS  computed value, held until the next done.
- rd_out  out  5  rd of the completed op, held with result.

Behaviour:
- FSM states: IDLE, CALC, DONE.
- Reset (async, any state): state=IDLE, counter=0, result=0, rd_out=0, done=0, busy=0, internal operand/accumulator regs=0.
- IDLE, start=1, valid op, flush=0:
  - Capture a, b, op, rd_in.
  - For DIV/REM, capture magnitudes and record the quotient sign (a[31]^b[31]) and remainder sign (a[31]).
  - Next state CALC, counter=0.
- IDLE, start=1 with op 6 or 7: ignored; no stall, stays IDLE.
- CALC:
  - One iteration per cycle: shift-add for MUL/MULHU (2*DBITS-bit product); restoring division for DIV/DIVU/REM/REMU.
  - counter increments each cycle. After exactly DBITS CALC cycles (counter==DBITS-1 on the last), go to DONE.
- DONE (one cycle):
  - Apply sign correction for signed divide, load result and rd_out, done=1.
  - Next state IDLE.
- Latency: start sampled in cycle T → CALC in T+1..T+DBITS → done=1 in T+DBITS+1. A back-to-back start is accepted in T+DBITS+2.
- stall_out (combinational):
  - = (state==IDLE & start & valid op & ~flush) | (state==CALC).
  - Low in DONE so AGEX advances and latches result that cycle.
- start while busy: ignored (AGEX is stalled, so it must stay asserted with the same op).
- Divide by zero (b==0):
  - DIV/DIVU quotient = all ones.
  - REM/REMU = a.
  - No exception; full latency.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Result selection:
  - MUL = product[DBITS-1:0].
  - MULHU = product[2*DBITS-1:DBITS].
- flush:
  - In CALC or DONE: next state IDLE, counter=0, done forced 0 that cycle; result/rd_out keep their previous values.
  - flush and start in the same IDLE cycle: flush wins; no capture, no stall.
- reset mid-CALC: immediate return to IDLE; no done pulse.

Optional Feature:
- Macro: MULDIV_FASTPATH_EN.
- Defined: in IDLE with an accepted start, skip CALC and go directly to DONE (done at T+1, stall_out high only in cycle T) when either:
  - op is MUL/MULHU and a==0 or b==0 (result 0), or
  - op is a divide/remainder and b==0 (divide-by-zero values above).
- Undefined: every accepted op takes the full DBITS+1 cycles to done.

Test Plan:
- MUL a=7, b=6, start at T: stall_out high T..T+32, done at T+33, result=42, rd_out=rd_in.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF: result=0xFFFFFFFE at done. DIV a=-20 (0xFFFFFFEC), b=3: result=0xFFFFFFFA (-6). REM same operands: result=0xFFFFFFFE (-2).
- DIVU a=100, b=0: result=0xFFFFFFFF. REMU a=100, b=0: result=100. With MULDIV_FASTPATH_EN, both give done at T+1.
- DIV a=0x80000000, b=0xFFFFFFFF: result=0x80000000. REM same operands: result=0.
- Start DIVU, assert flush at T+10: busy=0 and stall_out=0 from T+11, no done pulse, result unchanged. flush+start together in IDLE: no stall, busy stays 0.
- Assert reset at T+5 of a MUL: all outputs 0 immediately. A new MUL started after reset completes normally with the correct result.
